// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: sized/aligned stores and extended loads on a
// byte-lane data RAM, registered into the MEM/WB boundary with a debug read port.
module mem_access_stage #(
  parameter  int NBITS = 32,
  parameter  int RBITS = 5,
  parameter  int DEPTH = 256,
  localparam int ABITS = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [NBITS-1:0] MEM_result,
  input  logic [NBITS-1:0] MEM_Rt,
  input  logic [RBITS-1:0] MEM_rd,
  input  logic [4:0]       MEM_sizecontrol,
  input  logic             MEM_memtoreg,
  input  logic             MEM_memread,
  input  logic             MEM_regwrite,
  input  logic             MEM_memwrite,
  input  logic [ABITS-1:0] i_dbg_addr,
  output logic [NBITS-1:0] o_dbg_data,
  output logic [NBITS-1:0] WB_readdata,
  output logic [NBITS-1:0] WB_result,
  output logic [RBITS-1:0] WB_rd,
  output logic             WB_memtoreg,
  output logic             WB_regwrite,
  output logic             WB_misalign
);

  localparam int NLANES = NBITS / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // Address decode
  size_e            size;
  logic [1:0]       offset;
  logic [ABITS-1:0] word_idx;
  logic             aligned;
  logic             misalign;
  logic             do_store;
  logic             do_load;

  // Store lane steering
  logic [NLANES-1:0] byte_en;
  logic [NBITS-1:0]  wdata;

  // Data memory
  logic [NBITS-1:0] mem_q [DEPTH];

  // Load-side registers
  logic [NBITS-1:0] ld_word_q;
  logic             ld_valid_q;
  logic [1:0]       ld_offset_q;
  size_e            ld_size_q;
  logic             ld_zext_q;
  logic [NBITS-1:0] ld_shift;
  logic [NBITS-1:0] readdata;

  // MEM/WB registers
  logic [NBITS-1:0] result_q;
  logic [RBITS-1:0] rd_q;
  logic             memtoreg_q;
  logic             regwrite_q;
  logic             misalign_q;

  // High address bits wrap modulo DEPTH; sizecontrol[4:3] has no meaning here.
  logic unused_bits;
  assign unused_bits = ^{MEM_sizecontrol[4:3], MEM_result[NBITS-1:ABITS+2]};

  assign size     = size_e'(MEM_sizecontrol[1:0]);
  assign offset   = MEM_result[1:0];
  assign word_idx = MEM_result[ABITS+1:2];

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    aligned = 1'b0;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~offset[0];
      default: aligned = (offset == 2'b00);
    endcase
  end

  assign misalign = (MEM_memread | MEM_memwrite) & ~aligned;
  assign do_store = MEM_memwrite & aligned & i_enable;
  assign do_load  = MEM_memread & ~MEM_memwrite & aligned;

  always_comb begin
    byte_en = '0;
    wdata   = MEM_Rt;
    case (size)
      SZ_BYTE: begin
        byte_en = NLANES'(1) << offset;
        wdata   = {NLANES{MEM_Rt[7:0]}};
      end
      SZ_HALF: begin
        byte_en = NLANES'(3) << offset;
        wdata   = {(NLANES/2){MEM_Rt[15:0]}};
      end
      default: begin
        byte_en = '1;
        wdata   = MEM_Rt;
      end
    endcase
  end

  // NOTE: the RAM has no reset branch; its contents survive i_rst, which only
  // gates the write so a store coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (do_store && !i_rst) begin
      for (int b = 0; b < NLANES; b++) begin
        if (byte_en[b]) mem_q[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign o_dbg_data = mem_q[i_dbg_addr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ld_word_q   <= '0;
      ld_valid_q  <= 1'b0;
      ld_offset_q <= 2'b00;
      ld_size_q   <= SZ_BYTE;
      ld_zext_q   <= 1'b0;
    end else if (i_enable) begin
      ld_valid_q  <= do_load;
      ld_offset_q <= offset;
      ld_size_q   <= size;
      ld_zext_q   <= MEM_sizecontrol[2];
      if (do_load) ld_word_q <= mem_q[word_idx];
    end
  end

  // Lane select and extension happen after the edge on the registered word.
  always_comb begin
    ld_shift = ld_word_q >> {ld_offset_q, 3'b000};
    readdata = '0;
    if (ld_valid_q) begin
      case (ld_size_q)
        SZ_BYTE: readdata = ld_zext_q ? {{(NBITS-8){1'b0}}, ld_shift[7:0]}
                                      : {{(NBITS-8){ld_shift[7]}}, ld_shift[7:0]};
        SZ_HALF: readdata = ld_zext_q ? {{(NBITS-16){1'b0}}, ld_shift[15:0]}
                                      : {{(NBITS-16){ld_shift[15]}}, ld_shift[15:0]};
        default: readdata = ld_word_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      result_q   <= '0;
      rd_q       <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (i_enable) begin
      result_q   <= MEM_result;
      rd_q       <= MEM_rd;
      memtoreg_q <= MEM_memtoreg;
      regwrite_q <= MEM_regwrite & ~misalign;
      misalign_q <= misalign;
    end
  end

  assign WB_readdata = readdata;
  assign WB_result   = result_q;
  assign WB_rd       = rd_q;
  assign WB_memtoreg = memtoreg_q;
  assign WB_regwrite = regwrite_q;
  assign WB_misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte-array reference model, directed
// scenarios, mid-run reset and randomized traffic.
module tb_mem_access_stage;

  localparam int NBITS = 32;
  localparam int RBITS = 5;
  localparam int DEPTH = 256;
  localparam int ABITS = $clog2(DEPTH);
  localparam int NBYTES = DEPTH * 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_enable;
  logic [NBITS-1:0] MEM_result;
  logic [NBITS-1:0] MEM_Rt;
  logic [RBITS-1:0] MEM_rd;
  logic [4:0]       MEM_sizecontrol;
  logic             MEM_memtoreg;
  logic             MEM_memread;
  logic             MEM_regwrite;
  logic             MEM_memwrite;
  logic [ABITS-1:0] i_dbg_addr;
  logic [NBITS-1:0] o_dbg_data;
  logic [NBITS-1:0] WB_readdata;
  logic [NBITS-1:0] WB_result;
  logic [RBITS-1:0] WB_rd;
  logic             WB_memtoreg;
  logic             WB_regwrite;
  logic             WB_misalign;

  mem_access_stage #(.NBITS(NBITS), .RBITS(RBITS), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .MEM_result(MEM_result), .MEM_Rt(MEM_Rt), .MEM_rd(MEM_rd),
    .MEM_sizecontrol(MEM_sizecontrol), .MEM_memtoreg(MEM_memtoreg),
    .MEM_memread(MEM_memread), .MEM_regwrite(MEM_regwrite),
    .MEM_memwrite(MEM_memwrite), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
    .WB_readdata(WB_readdata), .WB_result(WB_result), .WB_rd(WB_rd),
    .WB_memtoreg(WB_memtoreg), .WB_regwrite(WB_regwrite), .WB_misalign(WB_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
    logic        mis;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: flat byte memory plus the architectural WB state.
  logic [7:0]  m_mem [NBYTES];
  logic [31:0] m_rdata, m_result;
  logic [4:0]  m_rd;
  logic        m_mtr, m_rw, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {m_mem[idx*4+3], m_mem[idx*4+2], m_mem[idx*4+1], m_mem[idx*4]};
  endfunction

  task automatic model_reset_wb();
    m_rdata = '0; m_result = '0; m_rd = '0; m_mtr = 1'b0; m_rw = 1'b0; m_mis = 1'b0;
  endtask

  task automatic issue(input logic en, input logic [31:0] res, input logic [31:0] rt,
                       input logic [4:0] rd, input logic [4:0] sc, input logic mtr,
                       input logic mr, input logic rw, input logic mw, input logic [7:0] dbg);
    int          nb, a;
    logic        ok;
    logic [31:0] v;
    exp_t        e;
    @(negedge i_clk);
    i_enable = en; MEM_result = res; MEM_Rt = rt; MEM_rd = rd; MEM_sizecontrol = sc;
    MEM_memtoreg = mtr; MEM_memread = mr; MEM_regwrite = rw; MEM_memwrite = mw;
    i_dbg_addr = dbg;
    nb = (sc[1:0] == 2'b00) ? 1 : (sc[1:0] == 2'b01) ? 2 : 4;
    a  = int'(res % 32'(NBYTES));
    ok = (a % nb) == 0;
    if (en) begin
      v = '0;
      if (mr && !mw && ok) begin
        for (int i = 0; i < nb; i++) v = v | (32'(m_mem[a+i]) << (8*i));
        if (nb < 4 && !sc[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      end
      if (mw && ok)
        for (int i = 0; i < nb; i++) m_mem[a+i] = 8'(rt >> (8*i));
      m_rdata = v; m_result = res; m_rd = rd; m_mtr = mtr;
      m_mis = (mr || mw) && !ok;
      m_rw  = rw && !m_mis;
    end
    e.rdata = m_rdata; e.result = m_result; e.rd = m_rd; e.mtr = m_mtr;
    e.rw = m_rw; e.mis = m_mis; e.dbg_addr = dbg; e.dbg = model_word(int'(dbg));
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock edge, sampled 2 time units after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("readdata", WB_readdata, e.rdata);
        check("result",   WB_result,   e.result);
        check("rd",       32'(WB_rd),  32'(e.rd));
        check("ctrl{mtr,rw,mis}", 32'({WB_memtoreg, WB_regwrite, WB_misalign}),
              32'({e.mtr, e.rw, e.mis}));
        check($sformatf("dbg[%0d]", e.dbg_addr), o_dbg_data, e.dbg);
      end
    end
  end

  initial begin
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    model_reset_wb();
    i_rst = 1'b1; i_enable = 1'b0; MEM_result = '0; MEM_Rt = '0; MEM_rd = '0;
    MEM_sizecontrol = '0; MEM_memtoreg = 1'b0; MEM_memread = 1'b0;
    MEM_regwrite = 1'b0; MEM_memwrite = 1'b0; i_dbg_addr = '0;
    #12;
    check("reset readdata", WB_readdata, 32'h0);
    check("reset result", WB_result, 32'h0);
    check("reset ctrl", 32'({WB_rd, WB_memtoreg, WB_regwrite, WB_misalign}), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Bring the RAM to a known all-zero state.
    for (int w = 0; w < DEPTH; w++)
      issue(1, 32'(w*4), 32'h0, 5'd0, 5'b00011, 0, 0, 0, 1, 8'(w));

    // Word store then sized loads ([4:3] set in places to show they are ignored).
    issue(1, 32'h10, 32'h8081_F2F3, 5'd1, 5'b00011, 0, 0, 0, 1, 8'd4);
    issue(1, 32'h10, 32'h0, 5'd2, 5'b11000, 1, 1, 1, 0, 8'd4);
    issue(1, 32'h13, 32'h0, 5'd3, 5'b00100, 1, 1, 1, 0, 8'd4);
    issue(1, 32'h12, 32'h0, 5'd4, 5'b01001, 1, 1, 1, 0, 8'd4);
    issue(1, 32'h10, 32'h0, 5'd5, 5'b00011, 1, 1, 1, 0, 8'd4);
    issue(1, 32'h10, 32'h0, 5'd5, 5'b00010, 1, 1, 1, 0, 8'd4);

    // Byte-lane stores into a zero word.
    issue(1, 32'h21, 32'hFFFF_FFAB, 5'd0, 5'b00000, 0, 0, 0, 1, 8'd8);
    issue(1, 32'h22, 32'hFFFF_1234, 5'd0, 5'b00001, 0, 0, 0, 1, 8'd8);
    issue(1, 32'h20, 32'h0, 5'd6, 5'b00011, 1, 1, 1, 0, 8'd8);

    // Misaligned store word and load half.
    issue(1, 32'h06, 32'hCAFE_BABE, 5'd7, 5'b00011, 0, 0, 1, 1, 8'd1);
    issue(1, 32'h05, 32'h0, 5'd8, 5'b00001, 1, 1, 1, 0, 8'd1);
    issue(1, 32'h07, 32'h1111_2222, 5'd9, 5'b00010, 0, 0, 1, 1, 8'd1);

    // Enable low holds everything; re-enabling completes the store.
    issue(0, 32'h30, 32'h5555_AAAA, 5'd10, 5'b00011, 0, 0, 0, 1, 8'd12);
    issue(0, 32'h30, 32'h5555_AAAA, 5'd10, 5'b00011, 0, 0, 0, 1, 8'd12);
    issue(1, 32'h30, 32'h5555_AAAA, 5'd10, 5'b00011, 0, 0, 0, 1, 8'd12);

    // Address wrap and read/write conflict.
    issue(1, 32'(DEPTH*4 + 4), 32'h0BAD_F00D, 5'd11, 5'b00011, 0, 0, 0, 1, 8'd1);
    issue(1, 32'h40, 32'h7777_8888, 5'd12, 5'b00011, 1, 1, 1, 1, 8'd16);
    issue(1, 32'h40, 32'h0, 5'd13, 5'b00011, 1, 1, 1, 0, 8'd16);

    // Asynchronous reset between edges; memory must survive, store under reset dropped.
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    check("async rst readdata", WB_readdata, 32'h0);
    check("async rst result", WB_result, 32'h0);
    check("async rst ctrl", 32'({WB_rd, WB_memtoreg, WB_regwrite, WB_misalign}), 32'h0);
    i_dbg_addr = 8'd4;
    #1;
    check("rst keeps mem", o_dbg_data, model_word(4));
    @(negedge i_clk);
    i_enable = 1'b1; MEM_result = 32'h10; MEM_Rt = 32'hDEAD_BEEF;
    MEM_sizecontrol = 5'b00011; MEM_memwrite = 1'b1; MEM_memread = 1'b0;
    @(posedge i_clk);
    #2;
    check("store under reset", o_dbg_data, model_word(4));
    @(negedge i_clk);
    i_enable = 1'b0; MEM_memwrite = 1'b0;
    i_rst = 1'b0;
    model_reset_wb();

    // Randomized traffic over a small window plus occasional high-address aliases.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] res;
      res = $urandom & 32'h0000_003F;
      if ($urandom_range(0, 3) == 0) res = res | ($urandom & 32'hFFFF_FC00);
      issue($urandom_range(0, 9) != 0, res, $urandom, 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 15)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge i_clk);
    #3;
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage MIPS pipeline: consumes the EX/MEM pipeline register outputs and performs the data-memory access, either a sized store or a sized, sign/zero-extended load. It also registers the results into the MEM/WB boundary. The block owns the data memory, a synchronous word-organised RAM with byte-lane writes. It flags misaligned accesses and exposes a combinational word-read port for the debug unit.

## Interface
- NBITS, 32, datapath width
- RBITS, 5, register-name width
- DEPTH, 256, data memory depth in words; ABITS = clog2(DEPTH)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  pipeline advance; 0 = hold all WB registers, no memory write
- MEM_result  in  NBITS  ALU result; byte address for loads/stores, pass-through value otherwise
- MEM_Rt  in  NBITS  store data
- MEM_rd  in  RBITS  destination register name
- MEM_sizecontrol  in  5  [1:0] size: 00 byte, 01 half, 11 word, 10 treated as word; [2] 1 = zero-extend load, 0 = sign-extend; [4:3] ignored
- MEM_memtoreg, MEM_memread, MEM_regwrite, MEM_memwrite  in  1 each  control from EX/MEM
- i_dbg_addr  in  ABITS  debug word index
- o_dbg_data  out  NBITS  memory word at i_dbg_addr, combinational
- WB_readdata  out  NBITS  extended load data
- WB_result  out  NBITS  registered MEM_result
- WB_rd  out  RBITS  registered MEM_rd
- WB_memtoreg, WB_regwrite  out  1  registered controls
- WB_misalign  out  1  registered misaligned-access flag

## Operation
- Address decode: word index = MEM_result[ABITS+1:2]; higher address bits ignored (wrap modulo DEPTH words). Byte offset = MEM_result[1:0].
- Little-endian: offset 0 is bits [7:0], offset 3 is bits [31:24].
- Alignment: byte always aligned; half requires offset[0]=0; word requires offset=00. Misaligned = (memread|memwrite) & !aligned.
- Store (memwrite & aligned & i_enable): byte writes MEM_Rt[7:0] into lane offset; half writes MEM_Rt[15:0] into lanes offset, offset+1; word writes all lanes. Other lanes unchanged.
- Load (memread & !memwrite & aligned): RAM word read synchronously at the edge. Offset, size and extend bit are registered alongside it. After the edge, WB_readdata = selected byte/half shifted to bits [7:0]/[15:0], then sign- or zero-extended; word passes unchanged.
- memread & memwrite both high: the store executes, the read is suppressed, and WB_readdata = 0.
- No load (memread=0, or misaligned): WB_readdata = 0.
- Misaligned access: no memory write. WB_misalign=1 and WB_regwrite=0 for that instruction. WB_result, WB_rd and WB_memtoreg pass normally.
- i_enable=0: WB registers hold, no write. The debug port remains live.
- Memory contents are not cleared by reset. Initial contents are zero in simulation.

## Timing
- Reset, asynchronous: WB_result=0, WB_rd=0, WB_memtoreg=0, WB_regwrite=0, WB_misalign=0, internal lane/size registers=0, hence WB_readdata=0. o_dbg_data is unaffected. Deassertion takes effect at the next rising edge.
- Latency: one cycle. Inputs presented in cycle N appear on the WB_* outputs after edge N.
- Store visibility: a store at edge N is visible to a load sampled at edge N+1 and to o_dbg_data immediately after edge N.
- Reset asserted mid-store: if i_rst is high at the edge, no write occurs.
- Back-to-back accesses each complete in one cycle. There is no stall generation.

## Test plan
- Reset: assert i_rst asynchronously between edges -> all WB_* outputs are 0 immediately. Memory is retained: o_dbg_data at a previously written index is unchanged.
- Word store then loads: store 0x8081_F2F3 at 0x10, then load byte signed @0x10, byte unsigned @0x13, half signed @0x12, word @0x10 -> WB_readdata = 0xFFFF_FFF3, 0x0000_0080, 0xFFFF_8081, 0x8081_F2F3.
- Byte-lane store: memory 0x0 at 0x20; store byte 0xAB @0x21, then half 0x1234 @0x22 -> o_dbg_data(8) = 0x1234_AB00.
- Misalignment: store word @0x06 with memwrite=1, regwrite=1 -> memory unchanged, WB_misalign=1 and WB_regwrite=0 for one cycle. A load half @0x05 gives the same response with WB_readdata=0.
- Enable/hold: i_enable=0 with a store @0x30 -> no write and WB outputs hold the previous values. Re-enabling -> the instruction completes on the next edge.
- Wrap and conflict: store @(DEPTH*4 + 4) -> word index 1 written. memread=memwrite=1 -> store done and WB_readdata=0.
